audio_tone_gen: RTL and testbench

Pixel-domain audio sample source for the HDMI audio path. Samples the 48 kHz audio clock as a data signal, advances a phase accumulator once per audio period and emits a stereo square-wave sample into a small first-word-fall-through FIFO. The HDMI audio packetizer drains that FIFO with a valid/ready handshake. The block sits directly downstream of the clock/reset generator and upstream of the audio packetizer.

---
 rtl/audio_tone_gen_pkg.sv | 18 +
 rtl/audio_sample_fifo.sv | 76 +++++++
 rtl/audio_tone_gen.sv | 117 +++++++++++
 tb/tb_audio_tone_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_tone_gen_pkg.sv
// Shared types for the pixel-domain audio tone source.
// Sample width, FSM states and the stereo sample bundle.
package audio_tone_gen_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_STEP = 2'd1,
        S_EMIT = 2'd2
    } audio_tone_state_t;

    typedef struct packed {
        logic [AUDIO_SAMPLE_WIDTH-1:0] l;
        logic [AUDIO_SAMPLE_WIDTH-1:0] r;
    } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through stereo sample FIFO with sticky overflow.
// Head holds the last popped sample while the FIFO is empty.
module audio_sample_fifo
    import audio_tone_gen_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = stereo_sample_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         push_data_i,
    input  logic                     pop_i,
    output T                         head_o,
    output logic                     valid_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    T               mem_q [DEPTH];
    T               last_q;
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    level_q;
    logic [AW:0]    level_d;
    logic           ovf_q;
    logic           pop;
    logic           push_ok;

    assign valid_o    = (level_q != '0);
    assign pop        = pop_i & valid_o;
    // A full FIFO still takes the push when the head leaves this cycle
    assign push_ok    = push_i & ((level_q != FULL) | pop);
    assign head_o     = valid_o ? mem_q[rd_q] : last_q;
    assign overflow_o = ovf_q;
    assign level_o    = level_q;

    always_comb begin
        level_d = level_q;
        if (push_ok & ~pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop & ~push_ok) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                last_q <= mem_q[rd_q];
                rd_q   <= rd_q + AW'(1);
            end
            if (push_i & ~push_ok) begin
                ovf_q <= 1'b1;
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/audio_tone_gen.sv
// Square-wave stereo tone source clocked by the pixel clock.
// Optional mute input when AUDIO_MUTE_EN is defined.
module audio_tone_gen
    import audio_tone_gen_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int PHASE_WIDTH  = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         I_clk_pixel,
    input  logic                         I_reset,
    input  logic                         I_clk_audio,
    input  logic [PHASE_WIDTH-1:0]       I_phase_inc,
    input  logic [SAMPLE_WIDTH-2:0]      I_amplitude,
`ifdef AUDIO_MUTE_EN
    input  logic                         I_mute,
`endif
    output logic [SAMPLE_WIDTH-1:0]      O_sample_l,
    output logic [SAMPLE_WIDTH-1:0]      O_sample_r,
    output logic                         O_valid,
    input  logic                         I_ready,
    output logic                         O_overflow,
    output logic [$clog2(FIFO_DEPTH):0]  O_level
);

    // Reset high so a high audio clock at release is not seen as an edge
    logic s1_q, s2_q, s3_q;
    logic tick;

    audio_tone_state_t       state_q, state_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic                    pending_q, pending_d;
    logic                    push;
    logic [SAMPLE_WIDTH-1:0] amp_ext;
    logic [SAMPLE_WIDTH-1:0] tone_l;
    logic [SAMPLE_WIDTH-1:0] tone_r;
    stereo_sample_t          push_data;
    stereo_sample_t          head;

    assign tick = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pending_d = pending_q;
        push      = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (tick | pending_q) begin
                    state_d   = S_STEP;
                    pending_d = 1'b0;
                end
            end
            S_STEP: begin
                phase_d   = phase_q + I_phase_inc;
                pending_d = pending_q | tick;
                state_d   = S_EMIT;
            end
            S_EMIT: begin
                push      = 1'b1;
                pending_d = pending_q | tick;
                state_d   = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        amp_ext = {1'b0, I_amplitude};
        tone_l  = phase_q[PHASE_WIDTH-1] ? -amp_ext : amp_ext;
        tone_r  = -tone_l;
`ifdef AUDIO_MUTE_EN
        if (I_mute) begin
            tone_l = '0;
            tone_r = '0;
        end
`endif
        push_data = '{l: tone_l, r: tone_r};
    end

    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s3_q      <= 1'b1;
            state_q   <= S_WAIT;
            phase_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            s1_q      <= I_clk_audio;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
        end
    end

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (stereo_sample_t)
    ) u_fifo (
        .clk_i       (I_clk_pixel),
        .rst_i       (I_reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (I_ready),
        .head_o      (head),
        .valid_o     (O_valid),
        .overflow_o  (O_overflow),
        .level_o     (O_level)
    );

    assign O_sample_l = head.l;
    assign O_sample_r = head.r;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench for audio_tone_gen with a per-cycle reference model.
// The model schedules pushes from audio edges and tracks the FIFO as a queue.
module tb_audio_tone_gen;

    localparam int PW    = 24;
    localparam int SW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          audio;
    logic          ready;
    logic [PW-1:0] inc;
    logic [SW-2:0] amp;
`ifdef AUDIO_MUTE_EN
    logic          mute;
`endif
    logic [SW-1:0] o_l;
    logic [SW-1:0] o_r;
    logic          o_valid;
    logic          o_ovf;
    logic [2:0]    o_level;

    int vectors     = 0;
    int miscompares = 0;

    audio_tone_gen #(
        .SAMPLE_WIDTH (SW),
        .PHASE_WIDTH  (PW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .I_clk_pixel (clk),
        .I_reset     (rst),
        .I_clk_audio (audio),
        .I_phase_inc (inc),
        .I_amplitude (amp),
`ifdef AUDIO_MUTE_EN
        .I_mute      (mute),
`endif
        .O_sample_l  (o_l),
        .O_sample_r  (o_r),
        .O_valid     (o_valid),
        .I_ready     (ready),
        .O_overflow  (o_ovf),
        .O_level     (o_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an audio rise seen at edge e is acted on at e+2,
    // the sample lands two edges after the FSM accepts it.
    int              edge_n;
    int              free_e;
    int              tk;
    int              sv;
    bit              a_prev;
    logic [PW-1:0]   m_phase;
    int              sched[$];
    logic [2*SW-1:0] fifo_q[$];
    logic [2*SW-1:0] m_last;
    bit              m_ovf;
    int              ma, ml, mr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n  = 0;
            free_e  = 0;
            a_prev  = 1'b1;
            m_phase = '0;
            sched.delete();
            fifo_q.delete();
            m_last  = '0;
            m_ovf   = 1'b0;
        end else begin
            edge_n++;
            if (audio && !a_prev) begin
                tk = edge_n + 2;
                sv = (tk > free_e) ? tk : free_e;
                sched.push_back(sv + 2);
                free_e = sv + 3;
            end
            a_prev = audio;
            if (ready && fifo_q.size() > 0) begin
                m_last = fifo_q.pop_front();
            end
            if (sched.size() > 0 && sched[0] == edge_n) begin
                void'(sched.pop_front());
                m_phase = m_phase + inc;
                ma = int'(amp);
                ml = m_phase[PW-1] ? -ma : ma;
`ifdef AUDIO_MUTE_EN
                if (mute) ml = 0;
`endif
                mr = -ml;
                if (fifo_q.size() < DEPTH) begin
                    fifo_q.push_back({ml[SW-1:0], mr[SW-1:0]});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    logic [2*SW-1:0] exp_head;

    always @(negedge clk) begin
        if (!rst) begin
            exp_head = (fifo_q.size() > 0) ? fifo_q[0] : m_last;
            chk("valid", 32'(o_valid), 32'(fifo_q.size() > 0));
            chk("level", 32'(o_level), 32'(fifo_q.size()));
            chk("overflow", 32'(o_ovf), 32'(m_ovf));
            chk("sample_l", 32'(o_l), 32'(exp_head[2*SW-1:SW]));
            chk("sample_r", 32'(o_r), 32'(exp_head[SW-1:0]));
        end
    end

    task automatic pulse(input int hi, input int lo);
        audio = 1'b1;
        repeat (hi) @(negedge clk);
        audio = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [SW-1:0] exp_l[4];
    logic [SW-1:0] exp_r[4];

    initial begin
        exp_l = '{16'h1000, 16'hF000, 16'hF000, 16'h1000};
        exp_r = '{16'hF000, 16'h1000, 16'h1000, 16'hF000};
        rst   = 1'b1;
        audio = 1'b1;
        ready = 1'b0;
        inc   = 24'h400000;
        amp   = 15'h1000;
`ifdef AUDIO_MUTE_EN
        mute  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_l", 32'(o_l), 32'd0);

        // Audio clock high through reset release: no tick
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_valid", 32'(o_valid), 32'd0);
        chk("idle_level", 32'(o_level), 32'd0);
        audio = 1'b0;
        repeat (5) @(negedge clk);

        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            audio = 1'b1;
            repeat (4) @(negedge clk);
            chk("lat_valid_e4", 32'(o_valid), 32'd0);
            @(negedge clk);
            chk("lat_valid_e5", 32'(o_valid), 32'd1);
            chk("tone_l", 32'(o_l), 32'(exp_l[k]));
            chk("tone_r", 32'(o_r), 32'(exp_r[k]));
            repeat (5) @(negedge clk);
            audio = 1'b0;
            repeat (10) @(negedge clk);
        end

        ready = 1'b0;
        repeat (4) pulse(3, 10);
        chk("fill_level", 32'(o_level), 32'd4);
        chk("fill_ovf", 32'(o_ovf), 32'd0);
        repeat (2) pulse(3, 10);
        chk("ovf_level", 32'(o_level), 32'd4);
        chk("ovf_set", 32'(o_ovf), 32'd1);
        chk("ovf_head", 32'(o_l), 32'h1000);
        ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("drained", 32'(o_level), 32'd0);

        reset_pulse();
        ready = 1'b0;
        repeat (4) pulse(3, 10);
        audio = 1'b1;
        repeat (4) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        chk("full_pop_level", 32'(o_level), 32'd4);
        chk("full_pop_ovf", 32'(o_ovf), 32'd0);
        repeat (10) @(negedge clk);
        audio = 1'b0;
        repeat (5) @(negedge clk);

        // Second rise lands while the FSM is busy
        reset_pulse();
        ready = 1'b0;
        audio = 1'b1;
        @(negedge clk);
        audio = 1'b0;
        @(negedge clk);
        audio = 1'b1;
        repeat (3) @(negedge clk);
        audio = 1'b0;
        repeat (12) @(negedge clk);
        chk("pend_level", 32'(o_level), 32'd2);
        chk("pend_head", 32'(o_l), 32'h1000);
        ready = 1'b1;
        @(negedge clk);
        chk("pend_second", 32'(o_l), 32'hF000);
        repeat (5) @(negedge clk);

        reset_pulse();
        ready = 1'b0;
        pulse(3, 10);
        audio = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_level", 32'(o_level), 32'd0);
        chk("mid_rst_l", 32'(o_l), 32'd0);
        chk("mid_rst_r", 32'(o_r), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_level", 32'(o_level), 32'd0);
        audio = 1'b0;
        repeat (5) @(negedge clk);

`ifdef AUDIO_MUTE_EN
        mute  = 1'b1;
        ready = 1'b0;
        repeat (2) pulse(3, 10);
        chk("mute_level", 32'(o_level), 32'd2);
        chk("mute_l", 32'(o_l), 32'd0);
        mute  = 1'b0;
        pulse(3, 10);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mute_phase_l", 32'(o_l), 32'hF000);
        repeat (5) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
